soc_bus_arbiter: RTL and testbench
==================================

// Module: soc_bus_arbiter
// PURPOSE
//  Two-master arbiter and address decoder for the SoC data bus (ROM port B, RAM, UART, GPIO).
//  M0 is the CPU data port; M1 is a secondary master such as a UART boot-loader or DMA.
//  Grants one master per cycle, drives the shared slave strobes and decodes a one-hot slave select.
//  Returns read data one cycle later, steered by a registered select.
// PARAMETERS
//  MAX_HOLD   4   max consecutive grants to one locked master while the other is requesting (1..15)
//  AW         32  address width; decode uses addr[AW-1:AW-4]
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset, synchronous, active-high
//  m0_req     in   1   M0 access request; held until m0_gnt
//  m0_lock    in   1   M0 asks to keep ownership on following cycles
//  m0_wen     in   1   1=write, 0=read
//  m0_addr    in   AW  byte address
//  m0_flag    in   4   byte enables
//  m0_wdata   in   32  write data
//  m0_gnt     out  1   access accepted this cycle
//  m0_rvld    out  1   read data valid (cycle after granted read)
//  m0_rdata   out  32  read data
//  m1_*       --   --  identical set for M1 (req, lock, wen, addr, flag, wdata, gnt, rvld, rdata)
//  s_cen      out  1   shared slave chip enable
//  s_wen      out  1   shared write enable
//  s_addr     out  AW  shared address
//  s_flag     out  4   shared byte enables
//  s_wdata    out  32  shared write data
//  s_sel      out  4   one-hot {gpio 0xD, uart 0xE, rom 0x0, ram 0x4}, gated by s_cen
//  s_rdata_*  in   32  read data from gpio/uart/rom/ram, valid the cycle after a strobe
// BEHAVIOUR
//  - Reset: gnt/rvld=0, rdata=0, s_cen=0, s_sel=0, s_wen=0, last=1 (M0 wins first), hold_cnt=0,
//    owner=NONE, sel_d=4'b0001.
//  - Arbitration is combinational on the current req/lock and registered state. gnt is same-cycle.
//    s_* mux the granted master's signals; all s_* are 0 when nothing is granted.
//  - FSM states: IDLE (no owner), OWN0, OWN1.
//    IDLE: if one master requests, grant it. If both request, grant !last (round-robin).
//    OWNx: stay in OWNx while mx_req && mx_lock && !(other req && hold_cnt==MAX_HOLD-1).
//      Otherwise re-arbitrate as in IDLE.
//  - hold_cnt increments on each consecutive grant to the same locked master while the other requests.
//    It clears on owner change or when the other is not requesting.
//  - On every grant, update last <= granted id.
//  - Read return: register sel_d <= s_sel and rid <= granted id with rd <= gnt & ~wen.
//    Next cycle, mRID_rvld = rd and mRID_rdata = the s_rdata selected by sel_d (priority gpio>uart>rom>ram).
//    The non-owning master gets rvld=0 and rdata holds its last value.
//  - Writes complete on the grant cycle; no response.
//  - Back-to-back grants allowed every cycle. A read followed by a grant to the other master still returns to the correct one.
//  - Simultaneous req with lock on both: round-robin applies; MAX_HOLD forces alternation.
//  - Reset mid-transfer: a pending rvld is dropped and FSM goes to IDLE on the next edge.
// CONFIGURATION
//  SOC_BUS_ERR_EN defined: an address whose top nibble matches no slave is still granted, with s_cen=0 and s_sel=0.
//    The next cycle raises mX_rvld with mX_rdata=32'hDEADBEEF and pulses mX_err (extra 1-bit output per master).
//  Undefined: mX_err ports are absent. An unmapped access is granted with s_cen=1, s_sel=0; a read returns s_rdata_ram.
// TESTING
//  1. M0 reads 0x40000010 alone -> m0_gnt=1, s_sel=0001, s_addr=0x40000010; next cycle m0_rvld=1, m0_rdata=s_rdata_ram.
//  2. M0 and M1 req together after reset, no lock -> grants alternate M0,M1,M0,M1 on consecutive cycles.
//  3. M1 locked, M0 requesting, MAX_HOLD=4 -> M1 granted 4 cycles, then M0 granted on the 5th.
//  4. M0 write 0xE0000004 data 0x41, flag 0001 -> s_cen=1, s_wen=1, s_sel=0100 for one cycle; no m0_rvld.
//  5. M0 read ROM 0x00000008, then M1 read GPIO 0xD0000000 -> m0_rvld with rom data, then m1_rvld with gpio data.
//  6. With SOC_BUS_ERR_EN: M1 reads 0x90000000 -> s_cen=0; next cycle m1_err=1, m1_rdata=0xDEADBEEF.
//     Also: assert rst while a read is granted -> no rvld on the following cycle.

Source files
------------

// File: rtl/soc_bus_arbiter_if.sv
// Master-side bundle of the SoC data bus, as seen by soc_bus_arbiter.
// The err response line exists only when SOC_BUS_ERR_EN is defined.
interface soc_bus_arbiter_if #(
  parameter int AW = 32
);
  logic          req;
  logic          lock;
  logic          wen;
  logic [AW-1:0] addr;
  logic [3:0]    flag;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvld;
  logic [31:0]   rdata;
`ifdef SOC_BUS_ERR_EN
  logic          err;

  modport master (output req, lock, wen, addr, flag, wdata, input gnt, rvld, rdata, err);
  modport slave  (input req, lock, wen, addr, flag, wdata, output gnt, rvld, rdata, err);
`else
  modport master (output req, lock, wen, addr, flag, wdata, input gnt, rvld, rdata);
  modport slave  (input req, lock, wen, addr, flag, wdata, output gnt, rvld, rdata);
`endif
endinterface

// File: rtl/soc_bus_arbiter.sv
// Two-master lock/round-robin arbiter with a 4-slave decoder and a one-cycle read return.
// Optional feature macro SOC_BUS_ERR_EN: unmapped accesses return 32'hDEADBEEF and pulse m*_err.
module soc_bus_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int AW       = 32
) (
  input  logic             clk,
  input  logic             rst,
  soc_bus_arbiter_if.slave m0,
  soc_bus_arbiter_if.slave m1,
  output logic             s_cen,
  output logic             s_wen,
  output logic [AW-1:0]    s_addr,
  output logic [3:0]       s_flag,
  output logic [31:0]      s_wdata,
  output logic [3:0]       s_sel,
  input  logic [31:0]      s_rdata_gpio,
  input  logic [31:0]      s_rdata_uart,
  input  logic [31:0]      s_rdata_rom,
  input  logic [31:0]      s_rdata_ram
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t      state, state_nxt;
  logic        last;
  logic [3:0]  hold_cnt, hold_nxt;
  logic        keep0, keep1;
  logic        gnt0, gnt1, any_gnt;
  logic [3:0]  dec;
  logic [3:0]  sel_d;
  logic        rid, rd;
  logic [31:0] ret_data, rdata0_q, rdata1_q;
`ifdef SOC_BUS_ERR_EN
  logic        mapped, err_d;
`endif

  // A locked owner keeps the bus until the other master has waited out MAX_HOLD grants.
  always_comb begin
    keep0 = (state == OWN0) && m0.req && m0.lock && !(m1.req && hold_cnt == HOLD_LAST);
    keep1 = (state == OWN1) && m1.req && m1.lock && !(m0.req && hold_cnt == HOLD_LAST);
    gnt0  = 1'b0;
    gnt1  = 1'b0;
    if (keep0) begin
      gnt0 = 1'b1;
    end else if (keep1) begin
      gnt1 = 1'b1;
    end else if (m0.req && m1.req) begin
      gnt0 = last;
      gnt1 = !last;
    end else if (m0.req) begin
      gnt0 = 1'b1;
    end else if (m1.req) begin
      gnt1 = 1'b1;
    end
    any_gnt = gnt0 | gnt1;

    state_nxt = IDLE;
    if (gnt0 && m0.lock) begin
      state_nxt = OWN0;
    end else if (gnt1 && m1.lock) begin
      state_nxt = OWN1;
    end

    hold_nxt = 4'd0;
    if ((gnt0 && state == OWN0 && m1.req) || (gnt1 && state == OWN1 && m0.req)) begin
      hold_nxt = hold_cnt + 4'd1;
    end
  end

  always_comb begin
    s_wen   = 1'b0;
    s_addr  = '0;
    s_flag  = 4'd0;
    s_wdata = 32'd0;
    if (gnt0) begin
      s_wen   = m0.wen;
      s_addr  = m0.addr;
      s_flag  = m0.flag;
      s_wdata = m0.wdata;
    end else if (gnt1) begin
      s_wen   = m1.wen;
      s_addr  = m1.addr;
      s_flag  = m1.flag;
      s_wdata = m1.wdata;
    end
  end

  always_comb begin
    case (s_addr[AW-1 -: 4])
      4'hD:    dec = 4'b1000;
      4'hE:    dec = 4'b0100;
      4'h0:    dec = 4'b0010;
      4'h4:    dec = 4'b0001;
      default: dec = 4'b0000;
    endcase
  end

`ifdef SOC_BUS_ERR_EN
  assign mapped = |dec;
  assign s_cen  = any_gnt & mapped;
`else
  assign s_cen  = any_gnt;
`endif
  assign s_sel  = dec & {4{s_cen}};

  // An empty sel_d (unmapped access) falls through to the RAM data.
  always_comb begin
    if (sel_d[3]) begin
      ret_data = s_rdata_gpio;
    end else if (sel_d[2]) begin
      ret_data = s_rdata_uart;
    end else if (sel_d[1]) begin
      ret_data = s_rdata_rom;
    end else begin
      ret_data = s_rdata_ram;
    end
`ifdef SOC_BUS_ERR_EN
    if (err_d) begin
      ret_data = 32'hDEADBEEF;
    end
`endif
  end

  assign m0.gnt   = gnt0;
  assign m1.gnt   = gnt1;
  assign m0.rvld  = rd & ~rid;
  assign m1.rvld  = rd & rid;
  assign m0.rdata = (rd & ~rid) ? ret_data : rdata0_q;
  assign m1.rdata = (rd & rid)  ? ret_data : rdata1_q;
`ifdef SOC_BUS_ERR_EN
  assign m0.err   = err_d & ~rid;
  assign m1.err   = err_d & rid;
`endif

  // The read-return registers remember who was served so the response follows them even if
  // the other master is granted in the very next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      hold_cnt <= 4'd0;
      sel_d    <= 4'b0001;
      rid      <= 1'b0;
      rd       <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
`ifdef SOC_BUS_ERR_EN
      err_d    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      if (any_gnt) begin
        last <= gnt1;
      end
      sel_d    <= s_sel;
      rid      <= gnt1;
`ifdef SOC_BUS_ERR_EN
      rd       <= any_gnt & (~s_wen | ~mapped);
      err_d    <= any_gnt & ~mapped;
`else
      rd       <= any_gnt & ~s_wen;
`endif
      rdata0_q <= m0.rdata;
      rdata1_q <= m1.rdata;
    end
  end

endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Scoreboard bench for soc_bus_arbiter: directed per-cycle stimulus queues the expected grants
// and read returns; a negedge monitor pops and compares them against what the DUT presents.
module tb_soc_bus_arbiter;

  localparam int          AW     = 32;
  localparam logic [31:0] GPIO_D = 32'hDDDD_0008;
  localparam logic [31:0] UART_D = 32'hEEEE_0004;
  localparam logic [31:0] ROM_D  = 32'h1234_0002;
  localparam logic [31:0] RAM_D  = 32'h4444_0001;
  localparam logic [31:0] ERR_D  = 32'hDEADBEEF;

  typedef struct packed {
    logic        req;
    logic        lock;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  flag;
  } mreq_t;

  typedef struct packed {
    int          cyc;
    int          id;
    logic [3:0]  sel;
    logic        cen;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  flag;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct packed {
    int          cyc;
    int          id;
    logic [31:0] data;
    logic        err;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_cen, s_wen;
  logic [AW-1:0] s_addr;
  logic [3:0]    s_flag, s_sel;
  logic [31:0]   s_wdata;
  logic [31:0]   s_rdata_gpio, s_rdata_uart, s_rdata_rom, s_rdata_ram;

  gnt_t        gntQ[$];
  rd_t         rdQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        rstDrive = 1'b1;
  bit          monEn = 1'b0;
  logic [31:0] hold0 = 32'd0;
  logic [31:0] hold1 = 32'd0;

  assign s_rdata_gpio = GPIO_D;
  assign s_rdata_uart = UART_D;
  assign s_rdata_rom  = ROM_D;
  assign s_rdata_ram  = RAM_D;

  soc_bus_arbiter_if #(.AW(AW)) m0 ();
  soc_bus_arbiter_if #(.AW(AW)) m1 ();

  soc_bus_arbiter #(.MAX_HOLD(4), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0           (m0),
    .m1           (m1),
    .s_cen        (s_cen),
    .s_wen        (s_wen),
    .s_addr       (s_addr),
    .s_flag       (s_flag),
    .s_wdata      (s_wdata),
    .s_sel        (s_sel),
    .s_rdata_gpio (s_rdata_gpio),
    .s_rdata_uart (s_rdata_uart),
    .s_rdata_rom  (s_rdata_rom),
    .s_rdata_ram  (s_rdata_ram)
  );

  always #5 clk = ~clk;

  function automatic mreq_t noReq();
    noReq = '{req: 1'b0, lock: 1'b0, wen: 1'b0, addr: 32'd0, wdata: 32'd0, flag: 4'd0};
  endfunction

  function automatic mreq_t rdReq(input logic [31:0] a, input logic l);
    rdReq = '{req: 1'b1, lock: l, wen: 1'b0, addr: a, wdata: 32'd0, flag: 4'hF};
  endfunction

  function automatic mreq_t wrReq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] f);
    wrReq = '{req: 1'b1, lock: 1'b0, wen: 1'b1, addr: a, wdata: d, flag: f};
  endfunction

  function automatic logic [31:0] expData(input logic [3:0] sel, input logic isErr);
    if (isErr)       expData = ERR_D;
    else if (sel[3]) expData = GPIO_D;
    else if (sel[2]) expData = UART_D;
    else if (sel[1]) expData = ROM_D;
    else             expData = RAM_D;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one bus cycle and queue whatever the DUT owes for it.
  task automatic applyStimulus(input mreq_t q0, input mreq_t q1, input int expId,
                               input logic [3:0] expSel, input logic expCen);
    mreq_t g;
    logic  isErr;
    @(posedge clk);
    #1;
    rst      = rstDrive;
    m0.req   = q0.req;  m0.lock = q0.lock; m0.wen = q0.wen;
    m0.addr  = q0.addr; m0.wdata = q0.wdata; m0.flag = q0.flag;
    m1.req   = q1.req;  m1.lock = q1.lock; m1.wen = q1.wen;
    m1.addr  = q1.addr; m1.wdata = q1.wdata; m1.flag = q1.flag;
    cyc++;
    if (expId >= 0) begin
      g = (expId == 0) ? q0 : q1;
      gntQ.push_back('{cyc: cyc, id: expId, sel: expSel, cen: expCen, wen: g.wen,
                       addr: g.addr, flag: g.flag, wdata: g.wdata});
      isErr = 1'b0;
`ifdef SOC_BUS_ERR_EN
      isErr = (expSel == 4'b0000);
`endif
      if (!rstDrive && (!g.wen || isErr)) begin
        rdQ.push_back('{cyc: cyc + 1, id: expId, data: expData(expSel, isErr), err: isErr});
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(noReq(), noReq(), -1, 4'b0000, 1'b0);
  endtask

  task automatic checkRead(input int id, input logic [31:0] data, input logic err);
    rd_t r;
    if (rdQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL m%0d_rvld_unexpected: got rvld=1 rdata=%h, expected no response (cycle %0d)",
               id, data, cyc);
    end else begin
      r = rdQ.pop_front();
      checkOutput("rvld_cycle", 32'(cyc), 32'(r.cyc));
      checkOutput("rvld_id", 32'(id), 32'(r.id));
      checkOutput("rdata", data, r.data);
      checkOutput("rvld_err", 32'(err), 32'(r.err));
      if (id == 0) hold0 = r.data;
      else         hold1 = r.data;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      hold0 = 32'd0;
      hold1 = 32'd0;
    end
  end

  always @(negedge clk) begin
    gnt_t g;
    logic e0, e1;
    if (monEn) begin
      e0 = 1'b0;
      e1 = 1'b0;
`ifdef SOC_BUS_ERR_EN
      e0 = m0.err;
      e1 = m1.err;
`endif
      if (m0.gnt && m1.gnt) begin
        checks++;
        errors++;
        $display("[TB] FAIL double_grant: got both gnt, expected at most one (cycle %0d)", cyc);
      end
      if (m0.gnt || m1.gnt) begin
        if (gntQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL gnt_unexpected: got m0_gnt=%0b m1_gnt=%0b, expected none (cycle %0d)",
                   m0.gnt, m1.gnt, cyc);
        end else begin
          g = gntQ.pop_front();
          checkOutput("gnt_cycle", 32'(cyc), 32'(g.cyc));
          checkOutput("gnt_id", 32'(m1.gnt), 32'(g.id));
          checkOutput("s_sel", 32'(s_sel), 32'(g.sel));
          checkOutput("s_cen", 32'(s_cen), 32'(g.cen));
          checkOutput("s_wen", 32'(s_wen), 32'(g.wen));
          checkOutput("s_addr", s_addr, g.addr);
          checkOutput("s_flag", 32'(s_flag), 32'(g.flag));
          checkOutput("s_wdata", s_wdata, g.wdata);
        end
      end else begin
        checkOutput("idle_s_cen", 32'(s_cen), 32'd0);
        checkOutput("idle_s_sel", 32'(s_sel), 32'd0);
        checkOutput("idle_s_addr", s_addr, 32'd0);
      end
      if (m0.rvld) checkRead(0, m0.rdata, e0);
      else begin
        checkOutput("m0_rdata_hold", m0.rdata, hold0);
        checkOutput("m0_err_idle", 32'(e0), 32'd0);
      end
      if (m1.rvld) checkRead(1, m1.rdata, e1);
      else begin
        checkOutput("m1_rdata_hold", m1.rdata, hold1);
        checkOutput("m1_err_idle", 32'(e1), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m0.req = 1'b0; m0.lock = 1'b0; m0.wen = 1'b0; m0.addr = '0; m0.wdata = '0; m0.flag = '0;
    m1.req = 1'b0; m1.lock = 1'b0; m1.wen = 1'b0; m1.addr = '0; m1.wdata = '0; m1.flag = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m0_gnt", 32'(m0.gnt), 32'd0);
    checkOutput("rst_m1_gnt", 32'(m1.gnt), 32'd0);
    checkOutput("rst_m0_rvld", 32'(m0.rvld), 32'd0);
    checkOutput("rst_m1_rvld", 32'(m1.rvld), 32'd0);
    checkOutput("rst_m0_rdata", m0.rdata, 32'd0);
    checkOutput("rst_m1_rdata", m1.rdata, 32'd0);
    checkOutput("rst_s_cen", 32'(s_cen), 32'd0);
    checkOutput("rst_s_sel", 32'(s_sel), 32'd0);
    checkOutput("rst_s_wen", 32'(s_wen), 32'd0);
    monEn    = 1'b1;
    rstDrive = 1'b0;

    $display("[TB] single M0 read from RAM");
    applyStimulus(rdReq(32'h4000_0010, 1'b0), noReq(), 0, 4'b0001, 1'b1);
    idleCycle();

    $display("[TB] round-robin after reset");
    rstDrive = 1'b1;
    idleCycle();
    rstDrive = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(rdReq(32'h4000_0020, 1'b0), rdReq(32'h0000_0100, 1'b0),
                    i % 2, (i % 2 == 0) ? 4'b0001 : 4'b0010, 1'b1);
    end
    idleCycle();

    $display("[TB] M1 lock limited by MAX_HOLD");
    applyStimulus(wrReq(32'h4000_0000, 32'h0000_00AA, 4'b0011), noReq(), 0, 4'b0001, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(rdReq(32'h4000_0040, 1'b0), rdReq(32'hD000_0000, 1'b1),
                    (i < 4) ? 1 : 0, (i < 4) ? 4'b1000 : 4'b0001, 1'b1);
    end
    idleCycle();

    $display("[TB] M0 write to UART");
    applyStimulus(wrReq(32'hE000_0004, 32'h0000_0041, 4'b0001), noReq(), 0, 4'b0100, 1'b1);
    idleCycle();

    $display("[TB] back-to-back ROM read M0 then GPIO read M1");
    applyStimulus(rdReq(32'h0000_0008, 1'b0), noReq(), 0, 4'b0010, 1'b1);
    applyStimulus(noReq(), rdReq(32'hD000_0000, 1'b0), 1, 4'b1000, 1'b1);
    idleCycle();

    $display("[TB] both masters locked alternate every MAX_HOLD grants");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(rdReq(32'h0000_0010, 1'b1), rdReq(32'hE000_0000, 1'b1),
                    (i >= 4 && i < 8) ? 1 : 0, (i >= 4 && i < 8) ? 4'b0100 : 4'b0010, 1'b1);
    end
    idleCycle();

    $display("[TB] unmapped read from M1");
`ifdef SOC_BUS_ERR_EN
    applyStimulus(noReq(), rdReq(32'h9000_0000, 1'b0), 1, 4'b0000, 1'b0);
`else
    applyStimulus(noReq(), rdReq(32'h9000_0000, 1'b0), 1, 4'b0000, 1'b1);
`endif
    idleCycle();

    $display("[TB] reset while a read is granted");
    rstDrive = 1'b1;
    applyStimulus(rdReq(32'h4000_0080, 1'b0), noReq(), 0, 4'b0001, 1'b1);
    rstDrive = 1'b0;
    applyStimulus(rdReq(32'h0000_0000, 1'b0), rdReq(32'h4000_0000, 1'b0), 0, 4'b0010, 1'b1);
    applyStimulus(noReq(), rdReq(32'h4000_0000, 1'b0), 1, 4'b0001, 1'b1);
    idleCycle();
    idleCycle();

    @(posedge clk);
    checkOutput("gnt_queue_drained", 32'(gntQ.size()), 32'd0);
    checkOutput("rd_queue_drained", 32'(rdQ.size()), 32'd0);
    monEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
